// File: rtl/alu_arbiter_seq_if.sv
// Bundle for the two requester channels, the tagged response channel and the shared ALU port.
// The slave modport is the arbiter. The master modport is everything around it.
interface alu_arbiter_seq_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_select;
  logic        req0_mode;
  logic        req0_wide;
  logic        req0_cin;
  logic [31:0] req0_a;
  logic [31:0] req0_b;

  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_select;
  logic        req1_mode;
  logic        req1_wide;
  logic        req1_cin;
  logic [31:0] req1_a;
  logic [31:0] req1_b;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_equal;

  logic [15:0] alu_in_a;
  logic [15:0] alu_in_b;
  logic [3:0]  alu_select;
  logic        alu_mode;
  logic        alu_carry_in;
  logic [15:0] alu_out;
  logic        alu_carry_out;
  logic        alu_compare;

  modport slave (
    input  req0_valid, req0_select, req0_mode, req0_wide, req0_cin, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_select, req1_mode, req1_wide, req1_cin, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_equal,
    input  rsp_ready,
    output alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
    input  alu_out, alu_carry_out, alu_compare
  );

  modport master (
    output req0_valid, req0_select, req0_mode, req0_wide, req0_cin, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_select, req1_mode, req1_wide, req1_cin, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_equal,
    output rsp_ready,
    input  alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
    output alu_out, alu_carry_out, alu_compare
  );
endinterface

// File: rtl/alu_arbiter_seq.sv
// Round-robin arbiter that shares one 16-bit combinational ALU between two requesters.
// 32-bit ops take two passes with carry chaining. Results return on one tagged response channel.
module alu_arbiter_seq #(
  parameter bit WIDE_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  alu_arbiter_seq_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StExecLo, StExecHi, StResp} state_e;

  state_e      state_q;
  logic        last_grant_q;
  logic [3:0]  cmd_select_q;
  logic        cmd_mode_q;
  logic        cmd_wide_q;
  logic        cmd_cin_q;
  logic        cmd_id_q;
  logic [31:0] cmd_a_q;
  logic [31:0] cmd_b_q;
  logic [31:0] result_q;
  logic        carry_q;
  logic        equal_q;
  logic        rsp_valid_q;

  logic grant0;
  logic grant1;

  // On a tie, the requester that did not win last time gets the grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_comb begin
    bus.alu_in_a     = '0;
    bus.alu_in_b     = '0;
    bus.alu_select   = '0;
    bus.alu_mode     = 1'b0;
    bus.alu_carry_in = 1'b0;
    case (state_q)
      StExecLo: begin
        bus.alu_in_a     = cmd_a_q[15:0];
        bus.alu_in_b     = cmd_b_q[15:0];
        bus.alu_select   = cmd_select_q;
        bus.alu_mode     = cmd_mode_q;
        bus.alu_carry_in = cmd_cin_q;
      end
      StExecHi: begin
        bus.alu_in_a     = cmd_a_q[31:16];
        bus.alu_in_b     = cmd_b_q[31:16];
        bus.alu_select   = cmd_select_q;
        bus.alu_mode     = cmd_mode_q;
        // Carry chains only for arithmetic; logic ops have no meaningful carry.
        bus.alu_carry_in = cmd_mode_q & carry_q;
      end
      default: ;
    endcase
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = cmd_id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.rsp_equal  = equal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      cmd_select_q <= '0;
      cmd_mode_q   <= 1'b0;
      cmd_wide_q   <= 1'b0;
      cmd_cin_q    <= 1'b0;
      cmd_id_q     <= 1'b0;
      cmd_a_q      <= '0;
      cmd_b_q      <= '0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      equal_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant0 || grant1) begin
            cmd_select_q <= grant1 ? bus.req1_select : bus.req0_select;
            cmd_mode_q   <= grant1 ? bus.req1_mode : bus.req0_mode;
            cmd_wide_q   <= (grant1 ? bus.req1_wide : bus.req0_wide) & WIDE_EN;
            cmd_cin_q    <= grant1 ? bus.req1_cin : bus.req0_cin;
            cmd_a_q      <= grant1 ? bus.req1_a : bus.req0_a;
            cmd_b_q      <= grant1 ? bus.req1_b : bus.req0_b;
            cmd_id_q     <= grant1;
            last_grant_q <= grant1;
            state_q      <= StExecLo;
          end
        end
        StExecLo: begin
          result_q <= {16'h0000, bus.alu_out};
          carry_q  <= bus.alu_carry_out;
          equal_q  <= bus.alu_compare;
          if (cmd_wide_q) begin
            state_q <= StExecHi;
          end else begin
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StExecHi: begin
          result_q[31:16] <= bus.alu_out;
          carry_q         <= bus.alu_carry_out;
          equal_q         <= equal_q & bus.alu_compare;
          rsp_valid_q     <= 1'b1;
          state_q         <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Directed and randomized bench for alu_arbiter_seq, with a behavioural ALU on the ALU port
// and a result/arbitration reference model.
module tb_alu_arbiter_seq;
  localparam bit WIDE_EN = 1'b1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_seq_if bus ();

  alu_arbiter_seq #(.WIDE_EN(WIDE_EN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit exp_last = 1'b1;

  logic        v      [2];
  logic [3:0]  p_sel  [2];
  logic        p_mode [2];
  logic        p_wide [2];
  logic        p_cin  [2];
  logic [31:0] p_a    [2];
  logic [31:0] p_b    [2];

  // Behavioural 16-bit ALU: 16 logic functions, plus add / subtract / increment arithmetic.
  function automatic logic [16:0] alu_f(input logic [3:0] sel, input logic mode,
                                        input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    logic [16:0] r;
    if (!mode) begin
      case (sel)
        4'h0: r = {1'b0, ~a};
        4'h1: r = {1'b0, ~(a | b)};
        4'h2: r = {1'b0, ~a & b};
        4'h3: r = 17'h0;
        4'h4: r = {1'b0, ~(a & b)};
        4'h5: r = {1'b0, ~b};
        4'h6: r = {1'b0, a ^ b};
        4'h7: r = {1'b0, a & ~b};
        4'h8: r = {1'b0, ~a | b};
        4'h9: r = {1'b0, ~(a ^ b)};
        4'hA: r = {1'b0, b};
        4'hB: r = {1'b0, a & b};
        4'hC: r = {1'b0, 16'hFFFF};
        4'hD: r = {1'b0, a | ~b};
        4'hE: r = {1'b0, a | b};
        default: r = {1'b0, a};
      endcase
    end else begin
      case (sel)
        4'h0: r = {1'b0, a} + 17'(cin);
        4'h6: r = {1'b0, a} + {1'b0, ~b} + 17'(cin);
        default: r = {1'b0, a} + {1'b0, b} + 17'(cin);
      endcase
    end
    return r;
  endfunction

  always_comb begin
    {bus.alu_carry_out, bus.alu_out} = alu_f(bus.alu_select, bus.alu_mode, bus.alu_in_a,
                                             bus.alu_in_b, bus.alu_carry_in);
    bus.alu_compare = (bus.alu_in_a == bus.alu_in_b);
  end

  always_comb begin
    bus.req0_valid  = v[0];
    bus.req0_select = p_sel[0];
    bus.req0_mode   = p_mode[0];
    bus.req0_wide   = p_wide[0];
    bus.req0_cin    = p_cin[0];
    bus.req0_a      = p_a[0];
    bus.req0_b      = p_b[0];
    bus.req1_valid  = v[1];
    bus.req1_select = p_sel[1];
    bus.req1_mode   = p_mode[1];
    bus.req1_wide   = p_wide[1];
    bus.req1_cin    = p_cin[1];
    bus.req1_a      = p_a[1];
    bus.req1_b      = p_b[1];
  end

  // Expected {carry, equal, result} for one whole command.
  function automatic logic [33:0] ref_rsp(input int g);
    logic [16:0] lo;
    logic [16:0] hi;
    logic        eq;
    lo = alu_f(p_sel[g], p_mode[g], p_a[g][15:0], p_b[g][15:0], p_cin[g]);
    eq = (p_a[g][15:0] == p_b[g][15:0]);
    if (p_wide[g] && WIDE_EN) begin
      hi = alu_f(p_sel[g], p_mode[g], p_a[g][31:16], p_b[g][31:16], p_mode[g] & lo[16]);
      return {hi[16], eq & (p_a[g][31:16] == p_b[g][31:16]), hi[15:0], lo[15:0]};
    end
    return {lo[16], eq, 16'h0000, lo[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_payload(input int g, input logic [3:0] sel, input logic mode,
                             input logic wide, input logic cin, input logic [31:0] a,
                             input logic [31:0] b);
    p_sel[g] = sel; p_mode[g] = mode; p_wide[g] = wide; p_cin[g] = cin;
    p_a[g] = a; p_b[g] = b;
  endtask

  task automatic rand_payload(input int g);
    set_payload(g, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                $urandom);
  endtask

  // Entered and left at negedge+1 with the DUT idle.
  task automatic transact(input logic [1:0] mask, input int stall);
    int          g;
    logic [33:0] exp;
    logic [16:0] lo;
    logic        ew;
    v[0] = mask[0];
    v[1] = mask[1];
    #1;
    g = (mask == 2'b01) ? 0 : (mask == 2'b10) ? 1 : (exp_last ? 0 : 1);
    check("grant_ready0", bus.req0_ready, g == 0);
    check("grant_ready1", bus.req1_ready, g == 1);
    exp_last = (g == 1);
    exp = ref_rsp(g);
    ew  = p_wide[g] & WIDE_EN;
    lo  = alu_f(p_sel[g], p_mode[g], p_a[g][15:0], p_b[g][15:0], p_cin[g]);
    @(posedge clk);
    @(negedge clk);
    v[g] = 1'b0;
    #1;
    check("lo_alu_a", bus.alu_in_a, p_a[g][15:0]);
    check("lo_alu_b", bus.alu_in_b, p_b[g][15:0]);
    check("lo_alu_cin", bus.alu_carry_in, p_cin[g]);
    check("lo_rsp_valid", bus.rsp_valid, 1'b0);
    check("lo_readies", {bus.req0_ready, bus.req1_ready}, 2'b00);
    if (ew) begin
      @(negedge clk);
      #1;
      check("hi_alu_a", bus.alu_in_a, p_a[g][31:16]);
      check("hi_alu_cin", bus.alu_carry_in, p_mode[g] & lo[16]);
      check("hi_rsp_valid", bus.rsp_valid, 1'b0);
    end
    @(negedge clk);
    #1;
    check("rsp_valid", bus.rsp_valid, 1'b1);
    check("rsp_id", bus.rsp_id, g);
    check("rsp_result", bus.rsp_result, exp[31:0]);
    check("rsp_carry", bus.rsp_carry, exp[33]);
    check("rsp_equal", bus.rsp_equal, exp[32]);
    check("resp_alu_a", bus.alu_in_a, 16'h0000);
    check("resp_readies", {bus.req0_ready, bus.req1_ready}, 2'b00);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      #1;
      check("stall_valid", bus.rsp_valid, 1'b1);
      check("stall_result", bus.rsp_result, exp[31:0]);
      check("stall_id", bus.rsp_id, g);
      check("stall_readies", {bus.req0_ready, bus.req1_ready}, 2'b00);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check("after_hs_valid", bus.rsp_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    v[0] = 1'b0;
    v[1] = 1'b0;
    set_payload(0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_payload(1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_result", bus.rsp_result, 32'h0);
    check("rst_alu_a", bus.alu_in_a, 16'h0);
    check("rst_alu_sel", bus.alu_select, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_readies", {bus.req0_ready, bus.req1_ready}, 2'b00);
    check("idle_rsp_valid", bus.rsp_valid, 1'b0);
    check("idle_alu_cin", bus.alu_carry_in, 1'b0);

    // Dual request after reset: req0 (narrow XOR) first, then the pending req1 (narrow add).
    set_payload(0, 4'b0110, 1'b0, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_0FF0);
    set_payload(1, 4'b1001, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 32'h0000_0001);
    transact(2'b11, 0);
    transact(2'b10, 2);

    // Wide add whose low half carries out into the high half, equal operands.
    set_payload(0, 4'b1001, 1'b1, 1'b1, 1'b0, 32'h1234_FFFF, 32'h1234_FFFF);
    transact(2'b01, 0);

    // Fairness with both held valid, one response stalled.
    rand_payload(0);
    rand_payload(1);
    for (int i = 0; i < 6; i++) transact(2'b11, (i == 2) ? 5 : 0);

    // Reset during the high pass: the command must vanish.
    v[0] = 1'b0;
    v[1] = 1'b0;
    set_payload(1, 4'b1001, 1'b1, 1'b1, 1'b1, 32'hAAAA_5555, 32'h1111_2222);
    v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v[1] = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_hi_a", bus.alu_in_a, 16'hAAAA);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", bus.rsp_valid, 1'b0);
    check("mid_rst_alu_a", bus.alu_in_a, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_valid", bus.rsp_valid, 1'b0);
    end
    rand_payload(0);
    rand_payload(1);
    transact(2'b11, 0);

    // Randomized commands, masks and stalls.
    for (int i = 0; i < 30; i++) begin
      v[0] = 1'b0;
      v[1] = 1'b0;
      rand_payload(0);
      rand_payload(1);
      transact(2'($urandom_range(1, 3)), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
